// File: rtl/p9c_pkg.sv
// Shared definitions for the LCD serial bus: command codes,
// bus idle levels and the received-byte record.
package p9c_pkg;

    localparam logic [7:0] LCD_SWRESET = 8'h01;
    localparam logic [7:0] LCD_SLPOUT  = 8'h11;
    localparam logic [7:0] LCD_DISPON  = 8'h29;
    localparam logic [7:0] LCD_CASET   = 8'h2A;
    localparam logic [7:0] LCD_RASET   = 8'h2B;
    localparam logic [7:0] LCD_RAMWR   = 8'h2C;

    localparam logic CSX_IDLE = 1'b1;
    localparam logic SCL_IDLE = 1'b0;
    localparam logic SDA_IDLE = 1'b0;
    localparam logic DCX_IDLE = 1'b0;

    typedef struct packed {
        logic       dc;
        logic [7:0] data;
    } rx_byte_t;

endpackage

// File: rtl/p9c_fifo.sv
// Synchronous show-ahead FIFO; head entry is visible on rdata_o
// whenever the FIFO is not empty.
module p9c_fifo #(
    parameter int WIDTH = 9,
    parameter int DEPTH = 4
) (
    input  logic             clk_i,
    input  logic             rst_ni,
    input  logic             push_i,
    input  logic [WIDTH-1:0] wdata_i,
    input  logic             pop_i,
    output logic [WIDTH-1:0] rdata_o,
    output logic             full_o,
    output logic             empty_o
);

    localparam int AW = $clog2(DEPTH);

    logic [WIDTH-1:0] mem_q [DEPTH];
    logic [AW:0]      wptr_q, wptr_d;
    logic [AW:0]      rptr_q, rptr_d;
    logic             wr_en;
    logic             rd_en;

    assign empty_o = (wptr_q == rptr_q);
    assign full_o  = (wptr_q[AW] != rptr_q[AW]) &&
                     (wptr_q[AW-1:0] == rptr_q[AW-1:0]);
    assign rd_en   = pop_i && !empty_o;
    assign wr_en   = push_i && (!full_o || rd_en);
    assign rdata_o = mem_q[rptr_q[AW-1:0]];

    // Pointer advance on accepted push / pop.
    always_comb begin
        wptr_d = wptr_q;
        rptr_d = rptr_q;
        if (wr_en) wptr_d = wptr_q + 1'b1;
        if (rd_en) rptr_d = rptr_q + 1'b1;
    end

    // Pointer registers with synchronous reset.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            wptr_q <= '0;
            rptr_q <= '0;
        end else begin
            wptr_q <= wptr_d;
            rptr_q <= rptr_d;
        end
    end

    // Storage array; contents need no reset.
    always_ff @(posedge clk_i) begin
        if (wr_en) mem_q[wptr_q[AW-1:0]] <= wdata_i;
    end

endmodule

// File: rtl/lcd_spi_rx.sv
// Receive side of the 4-wire LCD bus: synchronise, deserialise
// MSB-first bytes tagged with DCX, and queue them in a FIFO.
module lcd_spi_rx
    import p9c_pkg::*;
#(
    parameter int FIFO_DEPTH  = 4,
    parameter int SYNC_STAGES = 2
) (
    input  logic       clk,
    input  logic       resx,
    input  logic       csx,
    input  logic       scl,
    input  logic       sda,
    input  logic       dcx,
    output logic [7:0] rx_data,
    output logic       rx_dc,
    output logic       rx_valid,
    input  logic       rx_ready,
    output logic       busy,
    output logic       overflow,
    output logic       frame_err,
    input  logic       clr_err
);

    localparam logic [0:0] ST_IDLE  = 1'b0;
    localparam logic [0:0] ST_SHIFT = 1'b1;

    logic [SYNC_STAGES-1:0] csx_sync_q, scl_sync_q;
    logic [SYNC_STAGES-1:0] sda_sync_q, dcx_sync_q;
    logic       csx_s, scl_s, sda_s, dcx_s;
    logic       scl_prev_q;
    logic       scl_rise;
    logic [0:0] state_q, state_d;
    logic [2:0] cnt_q, cnt_d;
    logic [6:0] sr_q, sr_d;
    logic       push;
    logic       pop;
    logic       frame_set;
    logic       ovf_set;
    logic       overflow_q, overflow_d;
    logic       frame_err_q, frame_err_d;
    logic       fifo_full, fifo_empty;
    rx_byte_t   wr_byte, head;

    assign csx_s    = csx_sync_q[SYNC_STAGES-1];
    assign scl_s    = scl_sync_q[SYNC_STAGES-1];
    assign sda_s    = sda_sync_q[SYNC_STAGES-1];
    assign dcx_s    = dcx_sync_q[SYNC_STAGES-1];
    assign scl_rise = scl_s && !scl_prev_q;

    // Synchroniser chains and SCL edge history.
    always_ff @(posedge clk) begin
        if (!resx) begin
            csx_sync_q <= {SYNC_STAGES{CSX_IDLE}};
            scl_sync_q <= {SYNC_STAGES{SCL_IDLE}};
            sda_sync_q <= {SYNC_STAGES{SDA_IDLE}};
            dcx_sync_q <= {SYNC_STAGES{DCX_IDLE}};
            scl_prev_q <= SCL_IDLE;
        end else begin
            csx_sync_q <= {csx_sync_q[SYNC_STAGES-2:0], csx};
            scl_sync_q <= {scl_sync_q[SYNC_STAGES-2:0], scl};
            sda_sync_q <= {sda_sync_q[SYNC_STAGES-2:0], sda};
            dcx_sync_q <= {dcx_sync_q[SYNC_STAGES-2:0], dcx};
            scl_prev_q <= scl_s;
        end
    end

    // Receiver FSM: frame tracking, bit shifting and byte push.
    always_comb begin
        state_d   = state_q;
        cnt_d     = cnt_q;
        sr_d      = sr_q;
        push      = 1'b0;
        frame_set = 1'b0;
        case (state_q)
            ST_IDLE: begin
                if (!csx_s) begin
                    state_d = ST_SHIFT;
                    cnt_d   = 3'd0;
                end
            end
            ST_SHIFT: begin
                if (csx_s) begin
                    state_d   = ST_IDLE;
                    cnt_d     = 3'd0;
                    frame_set = (cnt_q != 3'd0);
                end else if (scl_rise) begin
                    sr_d  = {sr_q[5:0], sda_s};
                    cnt_d = cnt_q + 3'd1;
                    push  = (cnt_q == 3'd7);
                end
            end
            default: state_d = ST_IDLE;
        endcase
    end

    assign pop     = rx_valid && rx_ready;
    assign ovf_set = push && fifo_full && !pop;

    // Sticky flags: a set event wins over a simultaneous clear.
    always_comb begin
        overflow_d  = ovf_set || (overflow_q && !clr_err);
        frame_err_d = frame_set || (frame_err_q && !clr_err);
    end

    // Receiver state registers.
    always_ff @(posedge clk) begin
        if (!resx) begin
            state_q     <= ST_IDLE;
            cnt_q       <= 3'd0;
            sr_q        <= 7'd0;
            overflow_q  <= 1'b0;
            frame_err_q <= 1'b0;
        end else begin
            state_q     <= state_d;
            cnt_q       <= cnt_d;
            sr_q        <= sr_d;
            overflow_q  <= overflow_d;
            frame_err_q <= frame_err_d;
        end
    end

    assign wr_byte.dc   = dcx_s;
    assign wr_byte.data = {sr_q, sda_s};

    p9c_fifo #(
        .WIDTH($bits(rx_byte_t)),
        .DEPTH(FIFO_DEPTH)
    ) u_fifo (
        .clk_i  (clk),
        .rst_ni (resx),
        .push_i (push),
        .wdata_i(wr_byte),
        .pop_i  (pop),
        .rdata_o(head),
        .full_o (fifo_full),
        .empty_o(fifo_empty)
    );

    assign rx_valid  = !fifo_empty;
    assign rx_data   = rx_valid ? head.data : 8'h00;
    assign rx_dc     = rx_valid && head.dc;
    assign busy      = !csx_s;
    assign overflow  = overflow_q;
    assign frame_err = frame_err_q;

endmodule
